// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using shift-and-add-3
// (double dabble). It processes one operand bit per clock and has a
// start/busy/done handshake. A sticky flag records any digit carry out of
// the top BCD digit. That carry means the operand needed more digits than
// DIGITS provides.
//
// Timing: a start accepted at edge E0 shifts on edges E1..E(BIN_W). The
// result is registered on E(BIN_W) and done is high for the following cycle.
// The finishing edge E(BIN_W) also samples start. If start is high there,
// the next operand loads on that edge. With start held high, conversions
// therefore run one every BIN_W cycles with no idle gap.

module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd,
  output logic                ovf
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int DIG_W = 4 * DIGITS;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  state_e             state_q;
  logic [BIN_W-1:0]   opnd_q;
  logic [DIG_W-1:0]   dig_q;
  logic               sticky_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [DIG_W-1:0]   bcd_q;
  logic               ovf_q;

  // Values for one double-dabble step, used while in CONV.
  logic [DIG_W-1:0]   adj;
  logic [DIG_W-1:0]   dig_d;
  logic [BIN_W-1:0]   opnd_d;
  logic               sticky_d;
  logic               carry;

  // One double-dabble step: first add 3 to each digit above 4, then shift
  // {carry, digits, operand} left by one bit.
  always_comb begin
    // NOTE: give every combinational output a default before any conditional
    // update; a path that leaves it unassigned infers a latch.
    adj = dig_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_q[4*k +: 4] > 4'd4) begin
        adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
      end
    end
    carry    = adj[DIG_W-1];
    dig_d    = {adj[DIG_W-2:0], opnd_q[BIN_W-1]};
    opnd_d   = opnd_q << 1;
    sticky_d = sticky_q | carry;
  end

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath registers are reset as well. An aborted conversion
    // must leave no partial digits behind, and bcd must read 0 after reset.
    if (!rst_n) begin
      state_q  <= IDLE;
      opnd_q   <= '0;
      dig_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments. Every register
      // then sees pre-edge values, whatever the statement order. A later
      // assignment in this block overrides an earlier one.
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opnd_q   <= bin;
            dig_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= CNT_W'(BIN_W);
            busy_q   <= 1'b1;
            state_q  <= CONV;
          end
        end
        CONV: begin
          opnd_q   <= opnd_d;
          dig_q    <= dig_d;
          sticky_q <= sticky_d;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            bcd_q  <= dig_d;
            ovf_q  <= sticky_d;
            done_q <= 1'b1;
            if (start) begin
              // The finishing edge also accepts a new operand.
              opnd_q   <= bin;
              dig_q    <= '0;
              sticky_q <= 1'b0;
              cnt_q    <= CNT_W'(BIN_W);
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule
